// File: rtl/db_qp_ram_pkg.sv
// Shared types and width defaults for the deblocking QP store controller.
// The fallback widths apply when the codec-wide define file is not in the build.
`ifndef DB_QP_ADR_W
`define DB_QP_ADR_W 6
`endif
`ifndef DB_QP_DATA_W
`define DB_QP_DATA_W 20
`endif

package db_qp_ram_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_INIT_ENC = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_INIT = ST_INIT_ENC,
        ST_DONE = ST_DONE_ENC
    } qp_state_e;

    // Records which side won the most recent conflict.
    typedef enum logic {
        PRIO_WR_LAST = 1'b0,
        PRIO_RD_LAST = 1'b1
    } qp_prio_e;

endpackage

// File: rtl/db_qp_ram_sp_64x20.sv
// Behavioural model of the 64x20 single-port RAM macro with low-active cen/wen.
// Q updates only on a read access and holds otherwise.
module db_qp_ram_sp_64x20 #(
    parameter int DATA_W = `DB_QP_DATA_W,
    parameter int ADR_W  = `DB_QP_ADR_W
) (
    input  logic              clk,
    input  logic              cen,
    input  logic              wen,
    input  logic [ADR_W-1:0]  adr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**ADR_W];

    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!wen) begin
                mem[adr] <= d;
            end else begin
                q <= mem[adr];
            end
        end
    end

endmodule

// File: rtl/db_qp_ram_ctrl.sv
// Shares the QP RAM port between the CU writer and the deblock reader, runs the
// per-LCU default-fill sweep, and registers the read return.
module db_qp_ram_ctrl
    import db_qp_ram_pkg::*;
#(
    parameter int DATA_W = `DB_QP_DATA_W,
    parameter int ADR_W  = `DB_QP_ADR_W,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_start_i,
    input  logic [DATA_W-1:0] init_val_i,
    output logic              init_busy_o,
    output logic              init_done_o,
    input  logic              wr_req_i,
    input  logic [ADR_W-1:0]  wr_adr_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    output logic              wr_ack_o,
    input  logic              rd_req_i,
    input  logic [ADR_W-1:0]  rd_adr_i,
    output logic              rd_ack_o,
    output logic              rd_vld_o,
    output logic [DATA_W-1:0] rd_dat_o
);

    qp_state_e         state, state_nxt;
    qp_prio_e          prio, prio_nxt;
    logic [ADR_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] fill_val, fill_nxt;

    logic              ram_cen, ram_wen;
    logic [ADR_W-1:0]  ram_adr;
    logic [DATA_W-1:0] ram_d, ram_q;

    logic              rd_vld_p1;
    logic [DATA_W-1:0] rd_hold_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            prio  <= PRIO_RD_LAST;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        fill_val <= fill_nxt;
    end

    // Grants are also gated by rst_n so no access reaches the RAM while held in reset.
    always_comb begin
        state_nxt   = state;
        prio_nxt    = prio;
        cnt_nxt     = cnt;
        fill_nxt    = fill_val;
        wr_ack_o    = 1'b0;
        rd_ack_o    = 1'b0;
        init_done_o = 1'b0;
        ram_cen     = 1'b1;
        ram_wen     = 1'b1;
        ram_adr     = '0;
        ram_d       = '0;
        unique case (state)
            ST_IDLE: begin
                if (init_start_i) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                    fill_nxt  = init_val_i;
                end
                if (rst_n) begin
                    if (wr_req_i && rd_req_i) begin
                        if (prio == PRIO_RD_LAST) begin
                            wr_ack_o = 1'b1;
                            prio_nxt = PRIO_WR_LAST;
                        end else begin
                            rd_ack_o = 1'b1;
                            prio_nxt = PRIO_RD_LAST;
                        end
                    end else begin
                        wr_ack_o = wr_req_i;
                        rd_ack_o = rd_req_i;
                    end
                end
                if (wr_ack_o) begin
                    ram_cen = 1'b0;
                    ram_wen = 1'b0;
                    ram_adr = wr_adr_i;
                    ram_d   = wr_dat_i;
                end else if (rd_ack_o) begin
                    ram_cen = 1'b0;
                    ram_adr = rd_adr_i;
                end
            end
            ST_INIT: begin
                if (rst_n) begin
                    ram_cen = 1'b0;
                    ram_wen = 1'b0;
                    ram_adr = cnt;
                    ram_d   = fill_val;
                end
                cnt_nxt = cnt + 1'b1;
                if (cnt == ADR_W'(DEPTH - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                init_done_o = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign init_busy_o = (state == ST_INIT);

    db_qp_ram_sp_64x20 #(
        .DATA_W (DATA_W),
        .ADR_W  (ADR_W)
    ) u_qp_ram (
        .clk (clk),
        .cen (ram_cen),
        .wen (ram_wen),
        .adr (ram_adr),
        .d   (ram_d),
        .q   (ram_q)
    );

    // Read return stage: Q is live in the vld cycle, then frozen in the hold register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld_p1  <= 1'b0;
            rd_hold_p1 <= '0;
        end else begin
            rd_vld_p1 <= rd_ack_o;
            if (rd_vld_p1) begin
                rd_hold_p1 <= ram_q;
            end
        end
    end

    assign rd_vld_o = rd_vld_p1;
    assign rd_dat_o = rd_vld_p1 ? ram_q : rd_hold_p1;

endmodule
